// File: rtl/axi_sram_write_slave_if.sv
// AXI write-channel bundle (AW, W, B) between the interconnect mux and the
// SRAM write slave. The interconnect drives the master side.
interface axi_sram_write_slave_if #(
  parameter int IDS_W  = 8,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 4
);
  logic [IDS_W-1:0]  AWID;
  logic [ADDR_W-1:0] AWADDR;
  logic [LEN_W-1:0]  AWLEN;
  logic [2:0]        AWSIZE;
  logic [1:0]        AWBURST;
  logic              AWVALID;
  logic              AWREADY;

  logic [DATA_W-1:0] WDATA;
  logic [3:0]        WSTRB;
  logic              WLAST;
  logic              WVALID;
  logic              WREADY;

  logic [IDS_W-1:0]  BID;
  logic [1:0]        BRESP;
  logic              BVALID;
  logic              BREADY;

  modport master (
    output AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
    output WDATA, WSTRB, WLAST, WVALID,
    output BREADY,
    input  AWREADY, WREADY, BID, BRESP, BVALID
  );

  modport slave (
    input  AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
    input  WDATA, WSTRB, WLAST, WVALID,
    input  BREADY,
    output AWREADY, WREADY, BID, BRESP, BVALID
  );
endinterface

// File: rtl/axi_sram_write_slave.sv
// AXI write slave: accepts one AW burst at a time, streams W beats into a
// single-port word-addressed SRAM as byte-masked writes, returns one B.
// Shares the SRAM with the read slave via the read_busy/write_busy interlock.
module axi_sram_write_slave #(
  parameter int IDS_W   = 8,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int LEN_W   = 4,
  parameter int SRAM_AW = 14
) (
  input  logic                  clock,
  input  logic                  reset,
  axi_sram_write_slave_if.slave axi,
  input  logic                  read_busy,
  output logic                  write_busy,
  output logic                  sram_CS,
  output logic [3:0]            sram_WEB,
  output logic [SRAM_AW-1:0]    sram_A,
  output logic [DATA_W-1:0]     sram_DI
);

  typedef enum logic [1:0] {IDLE, DATA, RESP} state_t;

  // Beat counter is one bit wider than AWLEN so it can count past the
  // announced length and saturate at 2^LEN_W instead of wrapping.
  localparam logic [LEN_W:0] CNT_MAX = {1'b1, {LEN_W{1'b0}}};

  state_t             state;
  logic [IDS_W-1:0]   id_q;
  logic [SRAM_AW-1:0] addr_q;
  logic [LEN_W-1:0]   len_q;
  logic [1:0]         burst_q;
  logic               err_q;
  logic [LEN_W:0]     beat_cnt;

  logic aw_hs;
  logic w_hs;
  logic beat_writable;
  logic unused_addr_bits;

  assign aw_hs = axi.AWVALID && axi.AWREADY;
  assign w_hs  = axi.WVALID && axi.WREADY;

  // Only the word index is used; byte offset and high bits are ignored.
  assign unused_addr_bits = ^{axi.AWADDR[ADDR_W-1:SRAM_AW+2], axi.AWADDR[1:0]};

  assign axi.AWREADY = (state == IDLE) && !read_busy;
  assign axi.WREADY  = (state == DATA);
  assign axi.BVALID  = (state == RESP);
  assign axi.BID     = id_q;
  assign axi.BRESP   = ((state == RESP) && err_q) ? 2'b10 : 2'b00;
  assign write_busy  = (state != IDLE);

  assign beat_writable = !err_q && (beat_cnt <= {1'b0, len_q});

  // SRAM strobe follows the W handshake in the same cycle; erroneous or
  // surplus beats still pulse CS but with every byte write disabled.
  always_comb begin
    sram_CS  = 1'b0;
    sram_WEB = 4'hF;
    sram_A   = addr_q;
    sram_DI  = '0;
    if (w_hs) begin
      sram_CS = 1'b1;
      sram_DI = axi.WDATA;
      if (beat_writable) begin
        sram_WEB = ~axi.WSTRB;
      end
    end
  end

  // Burst control FSM: latch the AW, walk the beats, hold B until accepted.
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      id_q     <= '0;
      addr_q   <= '0;
      len_q    <= '0;
      burst_q  <= '0;
      err_q    <= 1'b0;
      beat_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (aw_hs) begin
            id_q     <= axi.AWID;
            addr_q   <= axi.AWADDR[SRAM_AW+1:2];
            len_q    <= axi.AWLEN;
            burst_q  <= axi.AWBURST;
            err_q    <= (axi.AWSIZE != 3'b010) || axi.AWBURST[1];
            beat_cnt <= '0;
            state    <= DATA;
          end
        end
        DATA: begin
          if (w_hs) begin
            if (beat_cnt != CNT_MAX) begin
              beat_cnt <= beat_cnt + 1'b1;
            end
            if (burst_q == 2'b01) begin
              addr_q <= addr_q + 1'b1;
            end
            if (beat_cnt > {1'b0, len_q}) begin
              err_q <= 1'b1;
            end
            if (axi.WLAST) begin
              if (beat_cnt != {1'b0, len_q}) begin
                err_q <= 1'b1;
              end
              state <= RESP;
            end
          end
        end
        RESP: begin
          if (axi.BREADY) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_sram_write_slave.sv
// Self-checking bench for axi_sram_write_slave: a table of directed bursts,
// randomized bursts against a behavioural SRAM-write model, and hand-written
// sequences for reset, interlock and response backpressure.
module tb_axi_sram_write_slave;

  localparam int IDS_W   = 8;
  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int LEN_W   = 4;
  localparam int SRAM_AW = 14;
  localparam int BOUND   = 50;

  typedef struct {
    logic [SRAM_AW-1:0] a;
    logic [3:0]         web;
    logic [DATA_W-1:0]  d;
  } wr_t;

  typedef struct {
    logic [IDS_W-1:0]  id;
    logic [ADDR_W-1:0] addr;
    logic [LEN_W-1:0]  len;
    logic [2:0]        size;
    logic [1:0]        burst;
    int                nbeats;
    logic [3:0]        strb;
    logic [DATA_W-1:0] data;
    logic              early_w;
    int                bdelay;
    logic [1:0]        exp_resp;
    int                exp_writes;
    logic [SRAM_AW-1:0] exp_first_a;
  } vec_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic read_busy = 1'b0;
  logic write_busy;
  logic sram_CS;
  logic [3:0] sram_WEB;
  logic [SRAM_AW-1:0] sram_A;
  logic [DATA_W-1:0] sram_DI;

  int total = 0;
  int bad = 0;

  wr_t obs_q[$];
  wr_t exp_q[$];
  vec_t vecs[9];

  always #5 clock = ~clock;

  axi_sram_write_slave_if #(.IDS_W(IDS_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) axi ();

  axi_sram_write_slave #(
    .IDS_W(IDS_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W), .SRAM_AW(SRAM_AW)
  ) dut (
    .clock(clock),
    .reset(reset),
    .axi(axi),
    .read_busy(read_busy),
    .write_busy(write_busy),
    .sram_CS(sram_CS),
    .sram_WEB(sram_WEB),
    .sram_A(sram_A),
    .sram_DI(sram_DI)
  );

  // Records every SRAM access that actually writes at least one byte.
  always @(negedge clock) begin
    if (sram_CS && sram_WEB != 4'hF) begin
      obs_q.push_back('{sram_A, sram_WEB, sram_DI});
    end
  end

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic send_aw(input logic [IDS_W-1:0] id, input logic [ADDR_W-1:0] addr,
                         input logic [LEN_W-1:0] len, input logic [2:0] size,
                         input logic [1:0] burst, input logic early_w,
                         input logic [DATA_W-1:0] d0, input logic [3:0] s0, input logic last0);
    logic hs;
    int cycles;
    axi.AWID = id; axi.AWADDR = addr; axi.AWLEN = len;
    axi.AWSIZE = size; axi.AWBURST = burst; axi.AWVALID = 1'b1;
    if (early_w) begin
      axi.WVALID = 1'b1; axi.WDATA = d0; axi.WSTRB = s0; axi.WLAST = last0;
    end
    cycles = 0;
    do begin
      @(negedge clock);
      hs = axi.AWREADY;
      @(posedge clock); #1;
      cycles++;
    end while (!hs && cycles < BOUND);
    if (!hs) check_output("aw_timeout", 64'd0, 64'd1);
    axi.AWVALID = 1'b0;
  endtask

  task automatic send_w(input logic [DATA_W-1:0] d, input logic [3:0] s, input logic last);
    logic hs;
    int cycles;
    axi.WVALID = 1'b1; axi.WDATA = d; axi.WSTRB = s; axi.WLAST = last;
    cycles = 0;
    do begin
      @(negedge clock);
      hs = axi.WREADY;
      @(posedge clock); #1;
      cycles++;
    end while (!hs && cycles < BOUND);
    if (!hs) check_output("w_timeout", 64'd0, 64'd1);
    axi.WVALID = 1'b0; axi.WLAST = 1'b0;
  endtask

  task automatic apply_stimulus(input vec_t v, output logic [1:0] resp_o,
                                output int count_o, output logic [SRAM_AW-1:0] first_a_o);
    logic [DATA_W-1:0] d[$];
    logic [3:0] s[$];
    logic illegal;
    logic [1:0] exp_resp;
    logic [SRAM_AW-1:0] word;
    logic hs;
    int cycles;

    for (int i = 0; i < v.nbeats; i++) begin
      d.push_back(v.data != 0 ? v.data + DATA_W'(i) : DATA_W'($urandom));
      s.push_back(v.strb != 0 ? v.strb : 4'($urandom_range(1, 15)));
    end

    // Reference: which beats land in the SRAM and what B must say.
    illegal = (v.size != 3'd2) || (v.burst == 2'b10) || (v.burst == 2'b11);
    word = v.addr[SRAM_AW+1:2];
    exp_q.delete();
    for (int i = 0; i < v.nbeats; i++) begin
      if (!illegal && i <= int'(v.len)) begin
        exp_q.push_back('{(v.burst == 2'b01) ? SRAM_AW'((int'(word) + i) % (1 << SRAM_AW)) : word,
                          ~s[i], d[i]});
      end
    end
    exp_resp = (illegal || v.nbeats != int'(v.len) + 1) ? 2'b10 : 2'b00;

    obs_q.delete();
    send_aw(v.id, v.addr, v.len, v.size, v.burst, v.early_w, d[0], s[0], v.nbeats == 1);
    for (int i = 0; i < v.nbeats; i++) begin
      send_w(d[i], s[i], i == v.nbeats - 1);
    end

    for (int k = 0; k < v.bdelay; k++) begin
      @(negedge clock);
      check_output("hold_bvalid", 64'(axi.BVALID), 64'd1);
      check_output("hold_bid", 64'(axi.BID), 64'(v.id));
      check_output("hold_bresp", 64'(axi.BRESP), 64'(exp_resp));
      check_output("hold_awready", 64'(axi.AWREADY), 64'd0);
      @(posedge clock); #1;
    end

    axi.BREADY = 1'b1;
    cycles = 0;
    resp_o = 2'b11;
    do begin
      @(negedge clock);
      hs = axi.BVALID;
      if (hs) begin
        check_output("bid", 64'(axi.BID), 64'(v.id));
        check_output("bresp", 64'(axi.BRESP), 64'(exp_resp));
        resp_o = axi.BRESP;
      end
      @(posedge clock); #1;
      cycles++;
    end while (!hs && cycles < BOUND);
    if (!hs) check_output("b_timeout", 64'd0, 64'd1);
    axi.BREADY = 1'b0;

    check_output("wr_count", 64'(obs_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      check_output($sformatf("wr%0d", i), {14'd0, obs_q[i].a, obs_q[i].web, obs_q[i].d},
                   {14'd0, exp_q[i].a, exp_q[i].web, exp_q[i].d});
    end
    count_o = obs_q.size();
    first_a_o = (obs_q.size() > 0) ? obs_q[0].a : '0;
  endtask

  initial begin
    logic [1:0] resp;
    int cnt;
    logic [SRAM_AW-1:0] fa;
    vec_t rv;
    int r;

    //          id     addr          len size burst nb strb   data          early bd resp  wr first
    vecs[0] = '{8'h5A, 32'h0000_0010, 0, 2, 2'b01, 1, 4'hF, 32'hDEADBEEF, 0, 0, 2'b00, 1, 14'h0004};
    vecs[1] = '{8'h11, 32'h0000_FFF8, 3, 2, 2'b01, 4, 4'h3, 32'h1111_0000, 0, 0, 2'b00, 4, 14'h3FFE};
    vecs[2] = '{8'h22, 32'h0000_0020, 2, 2, 2'b00, 3, 4'hF, 32'hA000_0000, 0, 0, 2'b00, 3, 14'h0008};
    vecs[3] = '{8'h33, 32'h0000_0040, 3, 2, 2'b01, 2, 4'hF, 32'hB000_0000, 0, 0, 2'b10, 2, 14'h0010};
    vecs[4] = '{8'h44, 32'h0000_0080, 1, 1, 2'b01, 2, 4'hF, 32'hC000_0000, 0, 0, 2'b10, 0, 14'h0000};
    vecs[5] = '{8'h55, 32'h0000_0084, 1, 2, 2'b10, 2, 4'hF, 32'hD000_0000, 0, 0, 2'b10, 0, 14'h0000};
    vecs[6] = '{8'h66, 32'h0000_0100, 1, 2, 2'b01, 2, 4'h9, 32'hE000_0000, 0, 5, 2'b00, 2, 14'h0040};
    vecs[7] = '{8'h77, 32'h0000_0200, 1, 2, 2'b01, 4, 4'hF, 32'hF000_0000, 0, 0, 2'b10, 2, 14'h0080};
    vecs[8] = '{8'h88, 32'h0000_0300, 2, 2, 2'b01, 3, 4'h6, 32'h1234_0000, 1, 0, 2'b00, 3, 14'h00C0};

    axi.AWID = '0; axi.AWADDR = '0; axi.AWLEN = '0; axi.AWSIZE = '0; axi.AWBURST = '0;
    axi.AWVALID = 1'b0; axi.WDATA = '0; axi.WSTRB = '0; axi.WLAST = 1'b0;
    axi.WVALID = 1'b0; axi.BREADY = 1'b0;

    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check_output("rst_wready", 64'(axi.WREADY), 64'd0);
    check_output("rst_bvalid", 64'(axi.BVALID), 64'd0);
    check_output("rst_bid", 64'(axi.BID), 64'd0);
    check_output("rst_bresp", 64'(axi.BRESP), 64'd0);
    check_output("rst_sram", {30'd0, sram_CS, sram_WEB, sram_A}, {30'd0, 1'b0, 4'hF, 14'd0});
    check_output("rst_di", 64'(sram_DI), 64'd0);
    check_output("rst_busy", 64'(write_busy), 64'd0);
    check_output("rst_awready", 64'(axi.AWREADY), 64'd1);
    @(posedge clock); #1;

    // Read side owns the SRAM: AW must be refused until it lets go.
    read_busy = 1'b1;
    axi.AWVALID = 1'b1; axi.AWSIZE = 3'd2; axi.AWBURST = 2'b01;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      check_output("rb_awready", 64'(axi.AWREADY), 64'd0);
      check_output("rb_busy", 64'(write_busy), 64'd0);
      @(posedge clock); #1;
    end
    axi.AWVALID = 1'b0;
    read_busy = 1'b0;
    @(negedge clock);
    check_output("rb_release", 64'(axi.AWREADY), 64'd1);
    @(posedge clock); #1;

    for (int i = 0; i < 9; i++) begin
      apply_stimulus(vecs[i], resp, cnt, fa);
      check_output($sformatf("vec%0d_resp", i), 64'(resp), 64'(vecs[i].exp_resp));
      check_output($sformatf("vec%0d_count", i), 64'(cnt), 64'(vecs[i].exp_writes));
      if (vecs[i].exp_writes > 0) begin
        check_output($sformatf("vec%0d_first_a", i), 64'(fa), 64'(vecs[i].exp_first_a));
      end
    end

    // Reset after the first beat of a 4-beat burst: no B, block idles.
    obs_q.delete();
    send_aw(8'h9C, 32'h0000_0400, 4'd3, 3'd2, 2'b01, 1'b0, '0, 4'h0, 1'b0);
    send_w(32'h5555_AAAA, 4'hF, 1'b0);
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    check_output("mid_rst_busy", 64'(write_busy), 64'd0);
    check_output("mid_rst_bvalid", 64'(axi.BVALID), 64'd0);
    check_output("mid_rst_wready", 64'(axi.WREADY), 64'd0);
    check_output("mid_rst_bid", 64'(axi.BID), 64'd0);
    check_output("mid_rst_awready", 64'(axi.AWREADY), 64'd1);
    check_output("mid_rst_writes", 64'(obs_q.size()), 64'd1);
    repeat (3) @(posedge clock);
    @(negedge clock);
    check_output("mid_rst_no_b", 64'(axi.BVALID), 64'd0);
    @(posedge clock); #1;
    apply_stimulus('{8'hA1, 32'h0000_0500, 4'd1, 3'd2, 2'b01, 2, 4'hF, 32'h0BAD_F00D, 1'b0, 0,
                     2'b00, 2, 14'h0140}, resp, cnt, fa);
    check_output("post_rst_resp", 64'(resp), 64'd0);
    check_output("post_rst_first_a", 64'(fa), 64'h140);

    for (int n = 0; n < 30; n++) begin
      rv.id = 8'($urandom);
      rv.addr = $urandom;
      rv.len = 4'($urandom_range(0, 7));
      rv.size = ($urandom_range(0, 7) == 0) ? 3'd1 : 3'd2;
      r = $urandom_range(0, 9);
      rv.burst = (r == 0) ? 2'($urandom_range(2, 3)) : 2'($urandom_range(0, 1));
      r = $urandom_range(0, 9);
      if (r == 0 && rv.len > 0) rv.nbeats = int'(rv.len);
      else if (r == 1) rv.nbeats = int'(rv.len) + 2;
      else rv.nbeats = int'(rv.len) + 1;
      rv.strb = 4'h0;
      rv.data = '0;
      rv.early_w = 1'($urandom_range(0, 1));
      rv.bdelay = $urandom_range(0, 3);
      rv.exp_resp = 2'b00; rv.exp_writes = 0; rv.exp_first_a = '0;
      apply_stimulus(rv, resp, cnt, fa);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/axi_sram_write_slave.md
Name: axi_sram_write_slave

Overview:
AXI write-channel slave port that sits directly downstream of the write interconnect's S0/S1 slave-side mux. It accepts one AW transaction, streams the W beats into a single-port word-addressed SRAM macro as byte-masked writes, and returns one B response. It shares the SRAM with the read-side slave through a simple busy interlock.

Parameters:
IDS_W, 8, slave-side ID width (master ID concatenated with transaction ID)
ADDR_W, 32, AXI address width
DATA_W, 32, data width; fixed 4 byte lanes
LEN_W, 4, AWLEN width
SRAM_AW, 14, SRAM word-address width; word index = AWADDR[SRAM_AW+1:2]

Ports:
clock  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
AWID  in  IDS_W  write address ID
AWADDR  in  ADDR_W  byte address of the first beat
AWLEN  in  LEN_W  beats minus 1
AWSIZE  in  3  beat size; only 3'b010 is legal
AWBURST  in  2  2'b00 FIXED, 2'b01 INCR, others illegal
AWVALID  in  1  AW valid
AWREADY  out  1  AW ready
WDATA  in  DATA_W  write data
WSTRB  in  4  byte strobes
WLAST  in  1  last beat
WVALID  in  1  W valid
WREADY  out  1  W ready
BID  out  IDS_W  response ID
BRESP  out  2  2'b00 OKAY, 2'b10 SLVERR
BVALID  out  1  B valid
BREADY  in  1  B ready
read_busy  in  1  read-side slave owns the SRAM
write_busy  out  1  this block owns the SRAM (state != IDLE)
sram_CS  out  1  chip select, active high
sram_WEB  out  4  per-byte write enable, active low
sram_A  out  SRAM_AW  word address
sram_DI  out  DATA_W  write data

Behaviour:
- FSM states: IDLE, DATA, RESP. On reset: state=IDLE; latched ID/addr/len/burst/err/beat_cnt cleared to 0.
- Output values after reset: WREADY=0, BVALID=0, BID=0, BRESP=0, sram_CS=0, sram_WEB=4'hF, sram_A=0, sram_DI=0, write_busy=0. AWREADY = !read_busy.
- IDLE: AWREADY = !read_busy, combinational.
  - On AW handshake (AWVALID && AWREADY): latch AWID, word index, AWLEN, AWBURST; set err=1 if AWSIZE!=3'b010 or AWBURST[1]==1; clear beat_cnt; go to DATA.
  - No AW is accepted in DATA or RESP. The minimum AW-to-AW spacing is therefore burst length + 2 cycles.
- DATA: WREADY=1.
  - On each W handshake, same cycle (combinational):
    - sram_CS=1, sram_A=current addr, sram_DI=WDATA.
    - sram_WEB=~WSTRB when err=0 and beat_cnt<=len; otherwise 4'hF (beat is consumed but not written).
  - Outside a handshake: sram_CS=0, sram_WEB=4'hF.
  - After each beat: beat_cnt+1 (saturates at 2^LEN_W).
  - Address update: INCR adds 1 word and wraps modulo 2^SRAM_AW; FIXED holds.
  - WLAST handshake: set err=1 if beat_cnt!=len (early, or late after extra beats); go to RESP.
  - Beats beyond len+1 without WLAST: accepted, suppressed, flagged err; the block waits for WLAST.
- RESP: BVALID=1, BID=latched ID, BRESP = err ? 2'b10 : 2'b00. Held stable until BREADY. On B handshake go to IDLE (AWREADY may assert the next cycle).
- write_busy=1 in DATA and RESP. read_busy is sampled only in IDLE; once AW is accepted the burst completes regardless of read_busy.
- Reset asserted mid-burst or mid-response: the burst is abandoned, no B is issued, and all outputs return to reset values the next cycle.
- Simultaneous AWVALID and WVALID in IDLE: only AW is taken; W is accepted from the next cycle.

Test Plan:
- Single write: AWADDR=0x0000_0010, LEN=0, SIZE=2, INCR, WSTRB=4'b1111, WDATA=0xDEADBEEF -> one sram write at A=4, WEB=4'h0, DI=0xDEADBEEF; BRESP=OKAY; BID=AWID.
- INCR burst: AWADDR=0x0000_FFF8, LEN=3, WSTRB=4'b0011 -> writes at A=0x3FFE, 0x3FFF, 0x0000, 0x0001 with WEB=4'b1100; OKAY.
- FIXED burst LEN=2 at 0x20 -> three writes all at A=8; last data wins; OKAY.
- Protocol errors:
  - Early WLAST on beat 2 of LEN=3 -> 2 writes, SLVERR.
  - AWSIZE=3'b001 -> all WEB=4'hF, SLVERR.
  - AWBURST=2'b10 -> SLVERR.
- Backpressure and interlock:
  - BREADY low for 5 cycles -> BVALID/BID/BRESP held stable, no new AWREADY.
  - read_busy=1 in IDLE -> AWREADY=0 until read_busy falls.
- Reset after beat 1 of LEN=3 -> no B issued, write_busy=0, next AW accepted normally.
